// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-unit result FIFOs retiring one entry per cycle to the regfile and scoreboard.
// Optional WB_RR_EN selects round-robin arbitration; otherwise fixed priority MUL > MEM > ALU.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  ex_wb_valid,
    input  logic [14:0] ex_wb_regdest,
    input  logic [95:0] ex_wb_data,
    input  logic [2:0]  ex_wb_writereg,
    input  logic [2:0]  ex_wb_ov,
    output logic [2:0]  wb_ex_stall,
    output logic        wb_reg_we,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_reg_data,
    output logic        wb_is_clr,
    output logic [4:0]  wb_is_clraddr,
    output logic [1:0]  wb_is_clrunit,
    output logic        wb_is_overflow
);

    localparam int EW = 38;

    logic [EW-1:0]  mem [3][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr [3];
    logic [PTR_W-1:0] wr_ptr [3];
    logic [PTR_W:0]   count  [3];
    logic [EW-1:0]  head [3];
    logic [EW-1:0]  sel;
    logic [2:0]     push;
    logic [2:0]     pop;
    logic [2:0]     nonempty;
    logic [1:0]     win;
    logic           any;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            wb_ex_stall[k] = (count[k] == (PTR_W + 1)'(FIFO_DEPTH));
            nonempty[k]    = (count[k] != '0);
            push[k]        = ex_wb_valid[k] & ex_wb_writereg[k] & ~wb_ex_stall[k];
            head[k]        = mem[k][rd_ptr[k]];
        end
    end

`ifdef WB_RR_EN
    // rr_ptr names the unit searched first: the one after the last winner
    logic [1:0] rr_ptr;

    always_comb begin
        win = 2'd0;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int j;
            j = (int'(rr_ptr) + i) % 3;
            if (!any && nonempty[j]) begin
                any = 1'b1;
                win = 2'(j);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 2'd0;
        end else if (any) begin
            rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end
`else
    always_comb begin
        win = 2'd0;
        any = |nonempty;
        if (nonempty[2]) begin
            win = 2'd2;
        end else if (nonempty[1]) begin
            win = 2'd1;
        end
    end
`endif

    always_comb begin
        pop = any ? (3'b001 << win) : 3'b000;
        case (win)
            2'd1:    sel = head[1];
            2'd2:    sel = head[2];
            default: sel = head[0];
        endcase
    end

    // Storage carries no reset; emptiness is tracked solely by count
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= {ex_wb_regdest[5*k +: 5],
                                      ex_wb_data[32*k +: 32],
                                      ex_wb_ov[k]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + 1'b1;
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_reg_we      <= 1'b0;
            wb_reg_addr    <= '0;
            wb_reg_data    <= '0;
            wb_is_clr      <= 1'b0;
            wb_is_clraddr  <= '0;
            wb_is_clrunit  <= '0;
            wb_is_overflow <= 1'b0;
        end else if (any) begin
            wb_reg_we      <= !sel[0] && (sel[37:33] != 5'd0);
            wb_reg_addr    <= sel[37:33];
            wb_reg_data    <= sel[32:1];
            wb_is_clr      <= 1'b1;
            wb_is_clraddr  <= sel[37:33];
            wb_is_clrunit  <= win + 2'd1;
            wb_is_overflow <= sel[0];
        end else begin
            wb_reg_we      <= 1'b0;
            wb_is_clr      <= 1'b0;
            wb_is_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: queue-based reference model feeds
// expected per-cycle retire records; a monitor compares them after each edge.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  ex_wb_valid = '0;
    logic [14:0] ex_wb_regdest = '0;
    logic [95:0] ex_wb_data = '0;
    logic [2:0]  ex_wb_writereg = '0;
    logic [2:0]  ex_wb_ov = '0;
    logic [2:0]  wb_ex_stall;
    logic        wb_reg_we;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic        wb_is_clr;
    logic [4:0]  wb_is_clraddr;
    logic [1:0]  wb_is_clrunit;
    logic        wb_is_overflow;

    writeback_arbiter dut (
        .clock(clock), .reset(reset),
        .ex_wb_valid(ex_wb_valid), .ex_wb_regdest(ex_wb_regdest),
        .ex_wb_data(ex_wb_data), .ex_wb_writereg(ex_wb_writereg),
        .ex_wb_ov(ex_wb_ov), .wb_ex_stall(wb_ex_stall),
        .wb_reg_we(wb_reg_we), .wb_reg_addr(wb_reg_addr),
        .wb_reg_data(wb_reg_data), .wb_is_clr(wb_is_clr),
        .wb_is_clraddr(wb_is_clraddr), .wb_is_clrunit(wb_is_clrunit),
        .wb_is_overflow(wb_is_overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
        logic        ov;
    } ent_t;

    typedef struct packed {
        logic        clr;
        logic        we;
        logic        ov;
        logic [2:0]  stall;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  unit;
    } exp_t;

    ent_t mq [3][$];
    exp_t exp_q [$];
    int tests = 0;
    int fails = 0;
`ifdef WB_RR_EN
    int nxt = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Model of the edge that follows: retire one head by the arbitration rule, then accept pushes
    task automatic apply(input logic [2:0] v, input logic [2:0] w, input logic [2:0] o,
                         input logic [14:0] rds, input logic [95:0] ds);
        int   s [3];
        int   win;
        ent_t h;
        exp_t e;
        ex_wb_valid = v;
        ex_wb_writereg = w;
        ex_wb_ov = o;
        ex_wb_regdest = rds;
        ex_wb_data = ds;
        e = '0;
        win = -1;
        for (int k = 0; k < 3; k++) s[k] = mq[k].size();
`ifdef WB_RR_EN
        for (int i = 0; i < 3; i++) begin
            if (win < 0 && s[(nxt + i) % 3] > 0) win = (nxt + i) % 3;
        end
`else
        for (int k = 0; k < 3; k++) if (s[k] > 0) win = k;
`endif
        if (win >= 0) begin
            h = mq[win].pop_front();
            e.clr = 1'b1;
            e.we = !h.ov && (h.rd != 5'd0);
            e.ov = h.ov;
            e.addr = h.rd;
            e.data = h.d;
            e.unit = 2'(win + 1);
`ifdef WB_RR_EN
            nxt = (win + 1) % 3;
`endif
        end
        for (int k = 0; k < 3; k++) begin
            if (v[k] && w[k] && s[k] < DEPTH) begin
                h = {rds[5*k +: 5], ds[32*k +: 32], o[k]};
                mq[k].push_back(h);
            end
        end
        for (int k = 0; k < 3; k++) e.stall[k] = (mq[k].size() == DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [2:0] v, input logic [2:0] w, input logic [2:0] o,
                        input logic [14:0] rds, input logic [95:0] ds);
        @(negedge clock);
        apply(v, w, o, rds, ds);
    endtask

    task automatic rstep(input logic [2:0] v, input logic [2:0] w, input logic [2:0] o);
        logic [95:0] ds;
        ds = {$urandom, $urandom, $urandom};
        step(v, w, o, 15'($urandom), ds);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000, 3'b000, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        ex_wb_valid = '0;
        for (int k = 0; k < 3; k++) mq[k].delete();
        exp_q.delete();
`ifdef WB_RR_EN
        nxt = 0;
`endif
        #1;
        chk("arst_clr", 64'(wb_is_clr), 64'd0);
        chk("arst_we", 64'(wb_reg_we), 64'd0);
        chk("arst_stall", 64'(wb_ex_stall), 64'd0);
        chk("arst_data", 64'(wb_reg_data), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        apply(3'b000, 3'b000, 3'b000, '0, '0);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (!reset) begin
            chk("rst_outs", {wb_ex_stall, wb_reg_we, wb_reg_addr, wb_is_clr,
                             wb_is_clraddr, wb_is_clrunit, wb_is_overflow}, 64'd0);
            chk("rst_data", 64'(wb_reg_data), 64'd0);
        end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL no_expect: DUT clr=%0b with no expected record", wb_is_clr);
        end else begin
            e = exp_q.pop_front();
            chk("clr", 64'(wb_is_clr), 64'(e.clr));
            chk("we", 64'(wb_reg_we), 64'(e.we));
            chk("overflow", 64'(wb_is_overflow), 64'(e.ov));
            chk("stall", 64'(wb_ex_stall), 64'(e.stall));
            if (e.clr) begin
                chk("reg_addr", 64'(wb_reg_addr), 64'(e.addr));
                chk("reg_data", 64'(wb_reg_data), 64'(e.data));
                chk("clraddr", 64'(wb_is_clraddr), 64'(e.addr));
                chk("clrunit", 64'(wb_is_clrunit), 64'(e.unit));
            end
        end
    end

    initial begin
        logic [2:0] v;
        logic [2:0] w;
        logic [2:0] o;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        apply(3'b000, 3'b000, 3'b000, '0, '0);
        // single ALU result
        step(3'b001, 3'b001, 3'b000, 15'd5, {64'd0, 32'hDEADBEEF});
        idle(2);
        // overflow on ALU, then write to $0 from MEM
        step(3'b001, 3'b001, 3'b001, 15'd8, {64'd0, 32'h12345678});
        step(3'b010, 3'b010, 3'b000, 15'd0, {32'd0, 32'hCAFEF00D, 32'd0});
        idle(2);
        // store on MEM: dropped
        step(3'b010, 3'b000, 3'b000, 15'd9 << 5, {32'd0, 32'h55AA55AA, 32'd0});
        idle(2);
        // contention for 3 cycles, then longer to fill a FIFO
        for (int i = 0; i < 3; i++) rstep(3'b111, 3'b111, 3'b000);
        idle(10);
        for (int i = 0; i < 7; i++) rstep(3'b111, 3'b111, 3'b000);
        idle(16);
        // same regdest from two units in one cycle
        step(3'b011, 3'b011, 3'b000, {5'd0, 5'd7, 5'd7}, {32'd0, 32'h2, 32'h1});
        idle(3);
        // reset with entries still queued
        for (int i = 0; i < 2; i++) rstep(3'b111, 3'b111, 3'b000);
        do_reset();
        idle(4);
        for (int i = 0; i < 400; i++) begin
            v = 3'($urandom);
            w = 3'($urandom) | 3'($urandom);
            o = 3'($urandom) & 3'($urandom);
            rstep(v, w, o);
        end
        idle(14);
        @(posedge clock);
        #2;
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
